sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 82 ++++++++
 tb/tb_sram_port_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter sharing one single-cycle SRAM between instruction fetch and
// load/store. Data wins by default; a starve counter eventually hands the port to fetch.
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       pend_inst;
    logic       pend_data;
    logic       inst_req_eff;
    logic       inst_wins;

    // A flushed fetch request is invisible to arbitration and to the starve counter.
    assign inst_req_eff = inst_req && !flush && !reset;
    assign inst_wins    = inst_req_eff && (starve_cnt == LIMIT);
    assign data_gnt     = !reset && data_req && !inst_wins;
    assign inst_gnt     = inst_req_eff && !data_gnt;

    always_comb begin
        sram_en    = inst_gnt || data_gnt;
        sram_wen   = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (data_gnt) begin
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (inst_gnt) begin
            sram_addr  = inst_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'h0;
        end else if (inst_req_eff && !inst_gnt) begin
            starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'h1;
        end else begin
            starve_cnt <= 4'h0;
        end
    end

    // Response stage: SRAM data returns one cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_inst <= 1'b0;
            pend_data <= 1'b0;
        end else begin
            pend_inst <= inst_gnt;
            pend_data <= data_gnt && (data_wen == 4'h0);
        end
    end

    assign inst_rvalid = pend_inst && !flush && !reset;
    assign data_rvalid = pend_data && !reset;
    assign inst_rdata  = sram_rdata;
    assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed and randomized bench for sram_port_arbiter against a cycle-level
// reference model of the arbitration and response rules.
module tb_sram_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: how long fetch has waited, and who owns next cycle's response.
    int   m_starve = 0;
    logic m_prev_inst = 1'b0;
    logic m_prev_load = 1'b0;
    logic m_ig, m_dg;
    logic [5:0] gnt_hist = 6'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dwd);
        logic        fetch_live;
        logic        e_irv, e_drv;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wdata;
        @(negedge clk);
        reset = r; flush = fl; inst_req = ir; inst_addr = ia;
        data_req = dr; data_wen = dw; data_addr = da; data_wdata = dwd;
        sram_rdata = $urandom;
        #1;
        fetch_live = !r && ir && !fl;
        if (r) begin
            m_dg = 1'b0;
            m_ig = 1'b0;
        end else begin
            m_dg = dr && !(fetch_live && m_starve == LIMIT);
            m_ig = fetch_live && !m_dg;
        end
        e_irv   = !r && m_prev_inst && !fl;
        e_drv   = !r && m_prev_load;
        e_wen   = m_dg ? dw : 4'h0;
        e_addr  = m_dg ? da : (m_ig ? ia : 32'h0);
        e_wdata = m_dg ? dwd : 32'h0;
        chk("inst_gnt", 32'(inst_gnt), 32'(m_ig));
        chk("data_gnt", 32'(data_gnt), 32'(m_dg));
        chk("sram_en", 32'(sram_en), 32'(m_ig | m_dg));
        chk("sram_wen", 32'(sram_wen), 32'(e_wen));
        chk("sram_addr", sram_addr, e_addr);
        chk("sram_wdata", sram_wdata, e_wdata);
        chk("inst_rvalid", 32'(inst_rvalid), 32'(e_irv));
        chk("data_rvalid", 32'(data_rvalid), 32'(e_drv));
        if (e_irv) chk("inst_rdata", inst_rdata, sram_rdata);
        if (e_drv) chk("data_rdata", data_rdata, sram_rdata);
        gnt_hist = {gnt_hist[4:0], inst_gnt};
        @(posedge clk);
        if (r) begin
            m_starve = 0;
            m_prev_inst = 1'b0;
            m_prev_load = 1'b0;
        end else begin
            m_prev_inst = m_ig;
            m_prev_load = m_dg && (dw == 4'h0);
            m_starve = (fetch_live && !m_ig) ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
        end
    endtask

    initial begin
        logic        ir, dr;
        logic [3:0]  dw;
        logic [31:0] ia, da, dwd;
        reset = 1'b1; flush = 1'b0; inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        sram_rdata = 32'h0;

        // Reset with both sides requesting: everything idle.
        step(1, 0, 1, 32'h1c000000, 1, 4'h0, 32'h40, 32'h0);
        step(1, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

        // Fetch only, then its response.
        step(0, 0, 1, 32'h1c000000, 0, 4'h0, 32'h0, 32'h0);
        chk("fetch_addr_dir", sram_addr, 32'h1c000000);
        step(0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

        // Collision: load wins, then load response.
        step(0, 0, 1, 32'h1c000004, 1, 4'h0, 32'h100, 32'h0);
        step(0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

        // Starvation: fetch gets cycle 4 of 6, data before and after.
        for (int i = 0; i < 6; i++)
            step(0, 0, 1, 32'h1c000008, 1, 4'h0, 32'h200 + 32'(i * 4), 32'h0);
        chk("starve_pattern", 32'(gnt_hist), 32'h02);
        step(0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

        // Store: write enables and data out, no response.
        step(0, 0, 0, 32'h0, 1, 4'hf, 32'h300, 32'hdeadbeef);
        chk("store_wdata_dir", sram_wdata, 32'hdeadbeef);
        step(0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

        // Flush in the response cycle, then flush with a live fetch request.
        step(0, 0, 1, 32'h1c000010, 0, 4'h0, 32'h0, 32'h0);
        step(0, 1, 1, 32'h1c000014, 0, 4'h0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

        // Reset while a fetch response is outstanding.
        step(0, 0, 1, 32'h1c000020, 0, 4'h0, 32'h0, 32'h0);
        step(1, 0, 1, 32'h1c000024, 1, 4'h0, 32'h44, 32'h0);
        step(0, 0, 1, 32'h1c000024, 0, 4'h0, 32'h0, 32'h0);

        // Random traffic; requesters hold their request until granted.
        ir = 0; dr = 0; dw = 0; ia = 0; da = 0; dwd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ir && ($urandom_range(0, 3) != 0)) begin
                ir = 1'b1; ia = $urandom & 32'hffff_fffc;
            end
            if (!dr && ($urandom_range(0, 2) != 0)) begin
                dr = 1'b1; da = $urandom; dwd = $urandom;
                dw = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
            end
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                 ir, ia, dr, dw, da, dwd);
            if (m_ig) ir = 1'b0;
            if (m_dg) dr = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
